// File: rtl/booth_seq_pkg.sv
// Shared types, default sizes and the signed clamp used by the Booth multiplier
// sequencer and its result accumulator.
package booth_seq_pkg;

  localparam int WIDTH_DEF       = 4;
  localparam int MUL_LATENCY_DEF = 4;
  localparam int ACC_W_DEF       = 12;

  // Wide enough to hold any accumulator sum this block is built with.
  localparam int SAT_MAX_W = 32;

  typedef logic signed [SAT_MAX_W:0] sat_wide_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    RUN,
    DONE
  } state_t;

  function automatic sat_wide_t sat_signed(input sat_wide_t sum, input int acc_w,
                                           output logic ovf);
    sat_wide_t hi;
    sat_wide_t lo;
    hi = (sat_wide_t'(1) <<< (acc_w - 1)) - sat_wide_t'(1);
    lo = -(sat_wide_t'(1) <<< (acc_w - 1));
    ovf = 1'b0;
    sat_signed = sum;
    if (sum > hi) begin
      sat_signed = hi;
      ovf = 1'b1;
    end else if (sum < lo) begin
      sat_signed = lo;
      ovf = 1'b1;
    end
  endfunction

endpackage

// File: rtl/booth_sat_acc.sv
// Running signed accumulator: either overwritten with the product or summed with
// it and clamped to the ACC_W signed range, with a sticky-per-operation ovf flag.
module booth_sat_acc
  import booth_seq_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int P_W   = 2 * WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             add,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  sat_wide_t        sum;
  sat_wide_t        sat;
  logic             sat_ovf;
  logic [ACC_W-1:0] p_ext;
  logic             unused_sat_hi;

  always_comb begin
    p_ext = ACC_W'($signed(p));
    sum   = sat_wide_t'($signed(acc)) + sat_wide_t'($signed(p));
    sat   = sat_signed(sum, ACC_W, sat_ovf);
  end

  // Clamped value always fits in ACC_W bits, so the upper part carries only sign.
  assign unused_sat_hi = ^sat[SAT_MAX_W:ACC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (add) begin
        acc <= sat[ACC_W-1:0];
        ovf <= sat_ovf;
      end else begin
        acc <= p_ext;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/booth_seq_sequencer.sv
// Feeds operand pairs to the Booth multiplier, times its fixed latency (it has no
// done flag) and returns the product plus a saturating running sum.
module booth_seq_sequencer
  import booth_seq_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
  input  logic               in_acc,
  output logic               mul_reset,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_ovf,
  output logic               busy
);

  // state | meaning
  // IDLE  | ready for an operand pair
  // CLR   | one-cycle clear pulse to the multiplier
  // LOAD  | one-cycle load pulse, latency counter preset
  // RUN   | counting down; product captured on terminal count
  // DONE  | result held until out_ready

  localparam int CNT_W = $clog2(MUL_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_PRESET = CNT_W'(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   q_r;
  logic               add_r;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_r;
  logic               capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_reset = 1'b0;
    mul_load  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CLR;
      end
      CLR: begin
        mul_reset = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        mul_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_ONE) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r    <= '0;
      q_r    <= '0;
      add_r  <= 1'b0;
      cnt    <= '0;
      prod_r <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        m_r   <= in_m;
        q_r   <= in_q;
        add_r <= in_acc;
      end
      if (state == LOAD)     cnt <= CNT_PRESET;
      else if (state == RUN) cnt <= cnt - CNT_ONE;
      if (capture) prod_r <= mul_p;
    end
  end

  booth_sat_acc #(
    .ACC_W(ACC_W),
    .P_W  (2 * WIDTH)
  ) u_acc (
    .clk  (clk),
    .reset(reset),
    .en   (capture),
    .add  (add_r),
    .p    (mul_p),
    .acc  (out_acc),
    .ovf  (out_ovf)
  );

  assign mul_m    = m_r;
  assign mul_q    = q_r;
  assign out_prod = prod_r;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_booth_seq_sequencer.sv
// Bench for booth_seq_sequencer: two instances (ACC_W 12 and 8) in lockstep, each
// driving a latency-accurate multiplier model, checked against an arithmetic model.
module tb_booth_seq_sequencer;

  localparam int W   = 4;
  localparam int LAT = 4;
  localparam int AW0 = 12;
  localparam int AW1 = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_acc;
  logic           out_ready;
  logic [W-1:0]   in_m;
  logic [W-1:0]   in_q;
  logic           in_ready  [2];
  logic           mul_reset [2];
  logic           mul_load  [2];
  logic           out_valid [2];
  logic           out_ovf   [2];
  logic           busy      [2];
  logic [W-1:0]   mul_m     [2];
  logic [W-1:0]   mul_q     [2];
  logic [2*W-1:0] mul_p     [2];
  logic [2*W-1:0] out_prod  [2];
  logic [AW0-1:0] out_acc0;
  logic [AW1-1:0] out_acc1;

  int checks = 0;
  int failures = 0;
  int acc_ref [2];
  bit ovf_ref [2];

  // multiplier stand-in: product valid only once LAT edges have passed the load
  int             mcnt  [2] = '{-1, -1};
  logic [2*W-1:0] mprod [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  booth_seq_sequencer #(.WIDTH(W), .MUL_LATENCY(LAT), .ACC_W(AW0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_m(in_m), .in_q(in_q), .in_acc(in_acc),
    .mul_reset(mul_reset[0]), .mul_load(mul_load[0]), .mul_m(mul_m[0]), .mul_q(mul_q[0]),
    .mul_p(mul_p[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_prod(out_prod[0]), .out_acc(out_acc0), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  booth_seq_sequencer #(.WIDTH(W), .MUL_LATENCY(LAT), .ACC_W(AW1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_m(in_m), .in_q(in_q), .in_acc(in_acc),
    .mul_reset(mul_reset[1]), .mul_load(mul_load[1]), .mul_m(mul_m[1]), .mul_q(mul_q[1]),
    .mul_p(mul_p[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_prod(out_prod[1]), .out_acc(out_acc1), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mul_reset[i]) begin
        mcnt[i]  <= -1;
        mprod[i] <= '0;
      end else if (mul_load[i]) begin
        mcnt[i]  <= LAT;
        mprod[i] <= 8'(int'($signed(mul_m[i])) * int'($signed(mul_q[i])));
      end else if (mcnt[i] > 0) begin
        mcnt[i] <= mcnt[i] - 1;
      end
    end
  end

  assign mul_p[0] = (mcnt[0] == 0) ? mprod[0] : 8'hA5;
  assign mul_p[1] = (mcnt[1] == 0) ? mprod[1] : 8'hA5;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] acc_of(input int i);
    return (i == 0) ? 32'($signed(out_acc0)) : 32'($signed(out_acc1));
  endfunction

  function automatic void ref_apply(input int i, input int p, input bit add);
    int w;
    int hi;
    int lo;
    int s;
    w  = (i == 0) ? AW0 : AW1;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    ovf_ref[i] = 1'b0;
    if (!add) begin
      acc_ref[i] = p;
    end else begin
      s = acc_ref[i] + p;
      if (s > hi) begin
        s = hi;
        ovf_ref[i] = 1'b1;
      end else if (s < lo) begin
        s = lo;
        ovf_ref[i] = 1'b1;
      end
      acc_ref[i] = s;
    end
  endfunction

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_bit($sformatf("%s_in_ready%0d", tag, i), in_ready[i], 1'b1);
      check_bit($sformatf("%s_busy%0d", tag, i), busy[i], 1'b0);
      check_bit($sformatf("%s_mul_reset%0d", tag, i), mul_reset[i], 1'b0);
      check_bit($sformatf("%s_mul_load%0d", tag, i), mul_load[i], 1'b0);
      check_val($sformatf("%s_mul_m%0d", tag, i), 32'(mul_m[i]), 0);
      check_val($sformatf("%s_mul_q%0d", tag, i), 32'(mul_q[i]), 0);
      check_bit($sformatf("%s_out_valid%0d", tag, i), out_valid[i], 1'b0);
      check_val($sformatf("%s_out_prod%0d", tag, i), 32'(out_prod[i]), 0);
      check_val($sformatf("%s_out_acc%0d", tag, i), acc_of(i), 0);
      check_bit($sformatf("%s_out_ovf%0d", tag, i), out_ovf[i], 1'b0);
    end
  endtask

  // One operation from accept to output handshake; called #1 after an edge in IDLE.
  task automatic do_op(input int m, input int q, input bit add, input int stall);
    int k;
    int rst_cnt, rst_first, ld_cnt, ld_first;
    bit opnd_bad, ctl_bad, stall_bad;
    logic [2*W-1:0] hp0, hp1;
    logic [AW0-1:0] ha0;
    logic [AW1-1:0] ha1;
    logic ho0, ho1;
    check_bit("ready_before_op", in_ready[0] & in_ready[1], 1'b1);
    in_m = W'(m);
    in_q = W'(q);
    in_acc = add;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_m = W'($urandom_range(15, 0));
    in_q = W'($urandom_range(15, 0));
    for (int i = 0; i < 2; i++) ref_apply(i, m * q, add);
    k = 0; rst_cnt = 0; rst_first = -1; ld_cnt = 0; ld_first = -1;
    opnd_bad = 0; ctl_bad = 0;
    while (!out_valid[0] && k < 30) begin
      if (mul_reset[0]) begin rst_cnt++; if (rst_first < 0) rst_first = k; end
      if (mul_load[0])  begin ld_cnt++;  if (ld_first < 0)  ld_first = k;  end
      for (int i = 0; i < 2; i++) begin
        if (mul_m[i] !== W'(m) || mul_q[i] !== W'(q)) opnd_bad = 1;
        if (busy[i] !== 1'b1 || in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0) ctl_bad = 1;
        if (mul_reset[i] !== mul_reset[0] || mul_load[i] !== mul_load[0]) ctl_bad = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    check_val("latency", k, LAT + 3);
    check_val("mul_reset_pulses", rst_cnt, 1);
    check_val("mul_reset_cycle", rst_first, 0);
    check_val("mul_load_pulses", ld_cnt, 1);
    check_val("mul_load_cycle", ld_first, 1);
    check_bit("operands_held", opnd_bad, 1'b0);
    check_bit("busy_phase_ctl", ctl_bad, 1'b0);
    check_bit("out_valid1", out_valid[1], 1'b1);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("out_prod%0d", i), 32'($signed(out_prod[i])), m * q);
      check_val($sformatf("out_acc%0d", i), acc_of(i), acc_ref[i]);
      check_bit($sformatf("out_ovf%0d", i), out_ovf[i], ovf_ref[i]);
    end
    hp0 = out_prod[0]; hp1 = out_prod[1]; ha0 = out_acc0; ha1 = out_acc1;
    ho0 = out_ovf[0]; ho1 = out_ovf[1];
    stall_bad = 0;
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_m = W'($urandom_range(15, 0));
      in_q = W'($urandom_range(15, 0));
      in_acc = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b1 || out_valid[1] !== 1'b1 || in_ready[0] !== 1'b0 ||
          in_ready[1] !== 1'b0 || out_prod[0] !== hp0 || out_prod[1] !== hp1 ||
          out_acc0 !== ha0 || out_acc1 !== ha1 || out_ovf[0] !== ho0 || out_ovf[1] !== ho1)
        stall_bad = 1;
    end
    if (stall > 0) check_bit("backpressure_stable", stall_bad, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check_bit($sformatf("ready_after_hs%0d", i), in_ready[i], 1'b1);
      check_bit($sformatf("valid_after_hs%0d", i), out_valid[i], 1'b0);
      check_bit($sformatf("busy_after_hs%0d", i), busy[i], 1'b0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, q, st;
    bit add;
    reset = 1'b0; in_valid = 1'b0; in_m = '0; in_q = '0; in_acc = 1'b0; out_ready = 1'b1;
    acc_ref = '{0, 0};
    ovf_ref = '{1'b0, 1'b0};
    #12;
    check_reset_state("por");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    do_op(5, 3, 1'b0, 0);
    check_val("tp_overwrite_acc", acc_of(0), 15);
    do_op(-5, 3, 1'b1, 0);
    check_val("tp_accum_prod", 32'($signed(out_prod[0])), -15);
    check_val("tp_accum_acc", acc_of(0), 0);
    do_op(-6, -5, 1'b0, 0);
    check_val("tp_negneg_acc", acc_of(0), 30);

    do_op(-8, -8, 1'b0, 0);
    do_op(-8, -8, 1'b1, 0);
    check_val("tp_sat_acc8", acc_of(1), 127);
    check_bit("tp_sat_ovf8", out_ovf[1], 1'b1);
    check_val("tp_nosat_acc12", acc_of(0), 128);
    do_op(1, 1, 1'b0, 0);
    check_val("tp_after_sat_acc8", acc_of(1), 1);
    check_bit("tp_after_sat_ovf8", out_ovf[1], 1'b0);
    for (int n = 0; n < 3; n++) do_op(-8, 7, 1'b1, 0);
    check_val("tp_negsat_acc8", acc_of(1), -128);

    do_op(3, -2, 1'b0, 3);

    in_m = W'(5); in_q = W'(3); in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_bit("mid_run_busy", busy[0], 1'b1);
    reset = 1'b0;
    #1;
    check_reset_state("mid_run");
    acc_ref = '{0, 0};
    ovf_ref = '{1'b0, 1'b0};
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_op(2, 3, 1'b1, 0);
    check_val("tp_after_reset_acc", acc_of(0), 6);

    for (int n = 0; n < 40; n++) begin
      m   = int'($urandom_range(15, 0)) - 8;
      q   = int'($urandom_range(15, 0)) - 8;
      add = 1'($urandom_range(1, 0) != 0 || n % 5 != 0);
      st  = (n % 4 == 0) ? int'($urandom_range(3, 1)) : 0;
      do_op(m, q, add, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
